// File: rtl/ctrl_axi_sequencer.sv
// AXI3-style slave that serializes read/write bursts into single-beat register requests.
// One transaction in flight; AR/AW arbitrated round-robin in IDLE.
module ctrl_axi_sequencer #(
    parameter logic [31:0] C_CTRL_MEM0_BASEADDR = 32'h6e400000,
    parameter logic [31:0] C_CTRL_MEM0_HIGHADDR = 32'h6e4fffff
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] ctrl_araddr,
    input  logic [11:0] ctrl_arid,
    input  logic [3:0]  ctrl_arlen,
    input  logic        ctrl_arvalid,
    output logic        ctrl_arready,
    output logic [31:0] ctrl_rdata,
    output logic [11:0] ctrl_rid,
    output logic [1:0]  ctrl_rresp,
    output logic        ctrl_rlast,
    output logic        ctrl_rvalid,
    input  logic        ctrl_rready,
    input  logic [31:0] ctrl_awaddr,
    input  logic [11:0] ctrl_awid,
    input  logic [3:0]  ctrl_awlen,
    input  logic        ctrl_awvalid,
    output logic        ctrl_awready,
    input  logic [31:0] ctrl_wdata,
    input  logic        ctrl_wlast,
    input  logic        ctrl_wvalid,
    output logic        ctrl_wready,
    output logic [11:0] ctrl_bid,
    output logic [1:0]  ctrl_bresp,
    output logic        ctrl_bvalid,
    input  logic        ctrl_bready,
    output logic        reg_req_valid,
    output logic        reg_req_write,
    output logic [31:0] reg_req_addr,
    output logic [31:0] reg_req_wdata,
    input  logic        reg_req_ready,
    input  logic [31:0] reg_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_DATA,
        S_WR_DATA,
        S_WR_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        dec_q, dec_d;
    logic        slv_q, slv_d;
    logic        last_wr_q, last_wr_d;

    logic [31:0] beat_addr;
    logic        beat_hit;
    logic        last_beat;
    logic        grant_rd;
    logic        grant_wr;

    // Every beat is decoded on its own, so a burst may straddle the window edge.
    assign beat_addr = addr_q + {26'd0, cnt_q, 2'b00};
    assign beat_hit  = (beat_addr >= C_CTRL_MEM0_BASEADDR) && (beat_addr <= C_CTRL_MEM0_HIGHADDR);
    assign last_beat = (cnt_q == len_q);

    assign grant_rd = ctrl_arvalid && (!ctrl_awvalid || last_wr_q);
    assign grant_wr = ctrl_awvalid && !grant_rd;

    assign ctrl_rdata    = rdata_q;
    assign ctrl_rresp    = rresp_q;
    assign ctrl_rid      = id_q;
    assign ctrl_bid      = id_q;
    assign ctrl_bresp    = dec_q ? 2'b11 : (slv_q ? 2'b10 : 2'b00);
    assign reg_req_addr  = beat_addr - C_CTRL_MEM0_BASEADDR;
    assign reg_req_wdata = ctrl_wdata;

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        dec_d         = dec_q;
        slv_d         = slv_q;
        last_wr_d     = last_wr_q;
        ctrl_arready  = 1'b0;
        ctrl_awready  = 1'b0;
        ctrl_rvalid   = 1'b0;
        ctrl_rlast    = 1'b0;
        ctrl_wready   = 1'b0;
        ctrl_bvalid   = 1'b0;
        reg_req_valid = 1'b0;
        reg_req_write = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ctrl_arready = grant_rd;
                ctrl_awready = grant_wr;
                if (grant_rd) begin
                    id_d      = ctrl_arid;
                    addr_d    = ctrl_araddr;
                    len_d     = ctrl_arlen;
                    cnt_d     = 4'd0;
                    last_wr_d = 1'b0;
                    state_d   = S_RD_ISSUE;
                end else if (grant_wr) begin
                    id_d      = ctrl_awid;
                    addr_d    = ctrl_awaddr;
                    len_d     = ctrl_awlen;
                    cnt_d     = 4'd0;
                    dec_d     = 1'b0;
                    slv_d     = 1'b0;
                    last_wr_d = 1'b1;
                    state_d   = S_WR_DATA;
                end
            end
            S_RD_ISSUE: begin
                if (beat_hit) begin
                    reg_req_valid = 1'b1;
                    if (reg_req_ready) begin
                        rdata_d = reg_rdata;
                        rresp_d = 2'b00;
                        state_d = S_RD_DATA;
                    end
                end else begin
                    rdata_d = 32'hdeadd00d;
                    rresp_d = 2'b11;
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                ctrl_rvalid = 1'b1;
                ctrl_rlast  = last_beat;
                if (ctrl_rready) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            S_WR_DATA: begin
                if (beat_hit) begin
                    reg_req_valid = ctrl_wvalid;
                    reg_req_write = 1'b1;
                    ctrl_wready   = reg_req_ready;
                end else begin
                    ctrl_wready = 1'b1;
                end
                if (ctrl_wvalid && ctrl_wready) begin
                    if (!beat_hit) dec_d = 1'b1;
                    if (ctrl_wlast != last_beat) slv_d = 1'b1;
                    // Beat count comes from awlen alone; a misplaced wlast only flags an error.
                    if (last_beat) begin
                        state_d = S_WR_RESP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_WR_RESP: begin
                ctrl_bvalid = 1'b1;
                if (ctrl_bready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            dec_q     <= 1'b0;
            slv_q     <= 1'b0;
            last_wr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            dec_q     <= dec_d;
            slv_q     <= slv_d;
            last_wr_q <= last_wr_d;
        end
    end

endmodule

// File: tb/tb_ctrl_axi_sequencer.sv
// Scoreboard bench: directed bursts push expected reg/R/B traffic; negedge monitors pop and compare.
module tb_ctrl_axi_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] ctrl_araddr;
    logic [11:0] ctrl_arid;
    logic [3:0]  ctrl_arlen;
    logic        ctrl_arvalid;
    logic        ctrl_arready;
    logic [31:0] ctrl_rdata;
    logic [11:0] ctrl_rid;
    logic [1:0]  ctrl_rresp;
    logic        ctrl_rlast;
    logic        ctrl_rvalid;
    logic        ctrl_rready;
    logic [31:0] ctrl_awaddr;
    logic [11:0] ctrl_awid;
    logic [3:0]  ctrl_awlen;
    logic        ctrl_awvalid;
    logic        ctrl_awready;
    logic [31:0] ctrl_wdata;
    logic        ctrl_wlast;
    logic        ctrl_wvalid;
    logic        ctrl_wready;
    logic [11:0] ctrl_bid;
    logic [1:0]  ctrl_bresp;
    logic        ctrl_bvalid;
    logic        ctrl_bready;
    logic        reg_req_valid;
    logic        reg_req_write;
    logic [31:0] reg_req_addr;
    logic [31:0] reg_req_wdata;
    logic        reg_req_ready;
    logic [31:0] reg_rdata;

    always #5 CLK = ~CLK;

    ctrl_axi_sequencer dut (
        .CLK(CLK), .RST_N(RST_N),
        .ctrl_araddr(ctrl_araddr), .ctrl_arid(ctrl_arid), .ctrl_arlen(ctrl_arlen),
        .ctrl_arvalid(ctrl_arvalid), .ctrl_arready(ctrl_arready),
        .ctrl_rdata(ctrl_rdata), .ctrl_rid(ctrl_rid), .ctrl_rresp(ctrl_rresp),
        .ctrl_rlast(ctrl_rlast), .ctrl_rvalid(ctrl_rvalid), .ctrl_rready(ctrl_rready),
        .ctrl_awaddr(ctrl_awaddr), .ctrl_awid(ctrl_awid), .ctrl_awlen(ctrl_awlen),
        .ctrl_awvalid(ctrl_awvalid), .ctrl_awready(ctrl_awready),
        .ctrl_wdata(ctrl_wdata), .ctrl_wlast(ctrl_wlast), .ctrl_wvalid(ctrl_wvalid),
        .ctrl_wready(ctrl_wready),
        .ctrl_bid(ctrl_bid), .ctrl_bresp(ctrl_bresp), .ctrl_bvalid(ctrl_bvalid),
        .ctrl_bready(ctrl_bready),
        .reg_req_valid(reg_req_valid), .reg_req_write(reg_req_write),
        .reg_req_addr(reg_req_addr), .reg_req_wdata(reg_req_wdata),
        .reg_req_ready(reg_req_ready), .reg_rdata(reg_rdata)
    );

    typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; } reg_exp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; logic [11:0] id; logic last; } r_exp_t;
    typedef struct { logic [11:0] id; logic [1:0] resp; } b_exp_t;

    reg_exp_t rq[$];
    r_exp_t   rrq[$];
    b_exp_t   bq[$];

    int n_cmp = 0;
    int n_err = 0;

    // Register-side responder: data from rd_base, one optional 3-cycle stall on request stall_at.
    logic [31:0] rd_base = 32'h0;
    int req_done  = 0;
    int stall_at  = -1;
    int stall_cnt = 0;
    assign reg_rdata     = rd_base;
    assign reg_req_ready = !((req_done == stall_at) && (stall_cnt < 3));

    always @(posedge CLK) begin
        if (RST_N && reg_req_valid) begin
            if (reg_req_ready) req_done <= req_done + 1;
            else               stall_cnt <= stall_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic to_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout", name);
    endtask

    reg_exp_t re;
    r_exp_t   ee;
    b_exp_t   be;

    always @(negedge CLK) begin
        if (RST_N && reg_req_valid && reg_req_ready) begin
            n_cmp++;
            if (rq.size() == 0) begin
                n_err++;
                $display("FAIL reg_req unexpected: wr=%b addr=%h", reg_req_write, reg_req_addr);
            end else begin
                re = rq.pop_front();
                if (reg_req_write !== re.wr || reg_req_addr !== re.addr ||
                    (re.wr && reg_req_wdata !== re.wdata)) begin
                    n_err++;
                    $display("FAIL reg_req: got wr=%b addr=%h wdata=%h want wr=%b addr=%h wdata=%h",
                             reg_req_write, reg_req_addr, reg_req_wdata, re.wr, re.addr, re.wdata);
                end
            end
        end
        if (RST_N && ctrl_rvalid && ctrl_rready) begin
            n_cmp++;
            if (rrq.size() == 0) begin
                n_err++;
                $display("FAIL r_beat unexpected: data=%h", ctrl_rdata);
            end else begin
                ee = rrq.pop_front();
                if (ctrl_rdata !== ee.data || ctrl_rresp !== ee.resp ||
                    ctrl_rid !== ee.id || ctrl_rlast !== ee.last) begin
                    n_err++;
                    $display("FAIL r_beat: got data=%h resp=%b id=%h last=%b want data=%h resp=%b id=%h last=%b",
                             ctrl_rdata, ctrl_rresp, ctrl_rid, ctrl_rlast, ee.data, ee.resp, ee.id, ee.last);
                end
            end
        end
        if (RST_N && ctrl_bvalid && ctrl_bready) begin
            n_cmp++;
            if (bq.size() == 0) begin
                n_err++;
                $display("FAIL b_resp unexpected: id=%h resp=%b", ctrl_bid, ctrl_bresp);
            end else begin
                be = bq.pop_front();
                if (ctrl_bid !== be.id || ctrl_bresp !== be.resp) begin
                    n_err++;
                    $display("FAIL b_resp: got id=%h resp=%b want id=%h resp=%b",
                             ctrl_bid, ctrl_bresp, be.id, be.resp);
                end
            end
        end
    end

    task automatic exp_reg(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        reg_exp_t e;
        e.wr = wr; e.addr = addr; e.wdata = wdata;
        rq.push_back(e);
    endtask

    task automatic exp_r(input logic [31:0] data, input logic [1:0] resp, input logic [11:0] id, input logic last);
        r_exp_t e;
        e.data = data; e.resp = resp; e.id = id; e.last = last;
        rrq.push_back(e);
    endtask

    task automatic exp_b(input logic [11:0] id, input logic [1:0] resp);
        b_exp_t e;
        e.id = id; e.resp = resp;
        bq.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ar(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len);
        ctrl_araddr = addr; ctrl_arid = id; ctrl_arlen = len; ctrl_arvalid = 1'b1;
    endtask

    task automatic set_aw(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len);
        ctrl_awaddr = addr; ctrl_awid = id; ctrl_awlen = len; ctrl_awvalid = 1'b1;
    endtask

    task automatic wait_ar();
        int n = 0;
        while (1) begin
            @(negedge CLK);
            if (ctrl_arready) break;
            n++;
            if (n > 100) begin to_fail("ar_handshake"); break; end
        end
        tick();
        ctrl_arvalid = 1'b0;
    endtask

    task automatic wait_aw();
        int n = 0;
        while (1) begin
            @(negedge CLK);
            if (ctrl_awready) break;
            n++;
            if (n > 100) begin to_fail("aw_handshake"); break; end
        end
        tick();
        ctrl_awvalid = 1'b0;
    endtask

    task automatic send_w(input int beats, input int wlast_pos, input logic [31:0] base);
        for (int i = 0; i < beats; i++) begin
            ctrl_wdata  = base + i;
            ctrl_wlast  = (i == wlast_pos);
            ctrl_wvalid = 1'b1;
            for (int n = 0; ; n++) begin
                @(negedge CLK);
                if (ctrl_wready) break;
                if (n > 100) begin to_fail("w_handshake"); break; end
            end
            tick();
        end
        ctrl_wvalid = 1'b0;
        ctrl_wlast  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (rq.size() != 0 || rrq.size() != 0 || bq.size() != 0) begin
            @(negedge CLK);
            n++;
            if (n > 200) begin to_fail("drain"); break; end
        end
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        RST_N = 1'b0;
        ctrl_araddr = '0; ctrl_arid = '0; ctrl_arlen = '0; ctrl_arvalid = 1'b0;
        ctrl_awaddr = '0; ctrl_awid = '0; ctrl_awlen = '0; ctrl_awvalid = 1'b0;
        ctrl_wdata = '0; ctrl_wlast = 1'b0; ctrl_wvalid = 1'b0;
        ctrl_rready = 1'b1; ctrl_bready = 1'b1;
        repeat (3) tick();

        @(negedge CLK);
        chk("rst_handshakes", {26'd0, ctrl_arready, ctrl_awready, ctrl_rvalid,
                               ctrl_bvalid, ctrl_wready, reg_req_valid}, 32'd0);
        chk("rst_rdata", ctrl_rdata, 32'd0);
        chk("rst_rid_bid", {8'd0, ctrl_rid, ctrl_bid}, 32'd0);
        chk("rst_resp_last", {27'd0, ctrl_rresp, ctrl_bresp, ctrl_rlast}, 32'd0);
        tick();
        RST_N = 1'b1;
        tick();

        // Single-beat read, immediate ready; AR-to-rvalid latency
        rd_base = 32'h12345678;
        exp_reg(1'b0, 32'h10, 32'h0);
        exp_r(32'h12345678, 2'b00, 12'h0a1, 1'b1);
        set_ar(32'h6e400010, 12'h0a1, 4'd0);
        wait_ar();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n++;
            if (ctrl_rvalid) break;
        end
        chk("rd_latency", n, 32'd2);
        drain();

        // 4-beat write with third request stalled three cycles
        stall_at = req_done + 2;
        for (int i = 0; i < 4; i++) exp_reg(1'b1, 32'(4 * i), 32'ha0000000 + 32'(i));
        exp_b(12'h3c2, 2'b00);
        set_aw(32'h6e400000, 12'h3c2, 4'd3);
        wait_aw();
        send_w(4, 3, 32'ha0000000);
        drain();
        chk("stall_cycles", stall_cnt, 32'd3);

        // Tie right after reset: read wins, write follows
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
        rd_base = 32'h55aa0001;
        exp_reg(1'b0, 32'h100, 32'h0);
        exp_r(32'h55aa0001, 2'b00, 12'h111, 1'b1);
        exp_reg(1'b1, 32'h200, 32'hb0000000);
        exp_b(12'h222, 2'b00);
        set_ar(32'h6e400100, 12'h111, 4'd0);
        set_aw(32'h6e400200, 12'h222, 4'd0);
        @(negedge CLK);
        chk("tie1_arready", {31'd0, ctrl_arready}, 32'd1);
        chk("tie1_awready", {31'd0, ctrl_awready}, 32'd0);
        tick();
        ctrl_arvalid = 1'b0;
        wait_aw();
        send_w(1, 0, 32'hb0000000);
        drain();

        // A lone read, then a tie: write now wins
        exp_reg(1'b0, 32'h300, 32'h0);
        exp_r(32'h55aa0001, 2'b00, 12'h333, 1'b1);
        set_ar(32'h6e400300, 12'h333, 4'd0);
        wait_ar();
        drain();
        exp_reg(1'b1, 32'h400, 32'hc0000000);
        exp_b(12'h444, 2'b00);
        exp_reg(1'b0, 32'h500, 32'h0);
        exp_r(32'h55aa0001, 2'b00, 12'h555, 1'b1);
        set_ar(32'h6e400500, 12'h555, 4'd0);
        set_aw(32'h6e400400, 12'h444, 4'd0);
        @(negedge CLK);
        chk("tie2_arready", {31'd0, ctrl_arready}, 32'd0);
        chk("tie2_awready", {31'd0, ctrl_awready}, 32'd1);
        tick();
        ctrl_awvalid = 1'b0;
        send_w(1, 0, 32'hc0000000);
        wait_ar();
        drain();

        // Read straddling the top of the window
        rd_base = 32'hcafef00d;
        exp_reg(1'b0, 32'h000ffffc, 32'h0);
        exp_r(32'hcafef00d, 2'b00, 12'h049, 1'b0);
        exp_r(32'hdeadd00d, 2'b11, 12'h049, 1'b1);
        set_ar(32'h6e4ffffc, 12'h049, 4'd1);
        wait_ar();
        drain();

        // Early wlast still takes awlen+1 beats, SLVERR
        exp_reg(1'b1, 32'h20, 32'hd0000000);
        exp_reg(1'b1, 32'h24, 32'hd0000001);
        exp_b(12'h050, 2'b10);
        set_aw(32'h6e400020, 12'h050, 4'd1);
        wait_aw();
        send_w(2, 0, 32'hd0000000);
        drain();

        // Write outside the window: DECERR, no register request
        exp_b(12'h051, 2'b11);
        set_aw(32'h70000000, 12'h051, 4'd0);
        wait_aw();
        send_w(1, 0, 32'he0000000);
        drain();

        // Reset while a read beat is stalled on rready
        ctrl_rready = 1'b0;
        exp_reg(1'b0, 32'h40, 32'h0);
        set_ar(32'h6e400040, 12'h0cc, 4'd0);
        wait_ar();
        n = 0;
        while (!ctrl_rvalid) begin
            @(negedge CLK);
            n++;
            if (n > 50) begin to_fail("rst_rvalid_wait"); break; end
        end
        tick();
        RST_N = 1'b0;
        tick();
        @(negedge CLK);
        chk("rst_mid_rvalid", {31'd0, ctrl_rvalid}, 32'd0);
        chk("rst_mid_rid", {20'd0, ctrl_rid}, 32'd0);
        tick();
        RST_N = 1'b1;
        ctrl_rready = 1'b1;
        tick();
        rd_base = 32'h0badcafe;
        exp_reg(1'b0, 32'h44, 32'h0);
        exp_r(32'h0badcafe, 2'b00, 12'h0cd, 1'b1);
        set_ar(32'h6e400044, 12'h0cd, 4'd0);
        wait_ar();
        drain();

        chk("reg_q_left", rq.size(), 32'd0);
        chk("r_q_left", rrq.size(), 32'd0);
        chk("b_q_left", bq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_axi_sequencer.md
CTRL_AXI_SEQUENCER -- requirements
Module: ctrl_axi_sequencer

Interface
REQ-001 SHALL have parameter C_CTRL_MEM0_BASEADDR, default 32'h6e400000, lowest decoded byte address.
REQ-002 SHALL have parameter C_CTRL_MEM0_HIGHADDR, default 32'h6e4fffff, highest decoded byte address.
REQ-003 CLK  input  1  single clock, all logic rising-edge.
REQ-004 RST_N  input  1  synchronous active-low reset.
REQ-005 ctrl_araddr  input  32  read burst start address.
REQ-006 ctrl_arid  input  12  read ID.
REQ-007 ctrl_arlen  input  4  read beats minus one.
REQ-008 ctrl_arvalid  input  1  AR valid.
REQ-009 ctrl_arready  output  1  AR accept.
REQ-010 ctrl_rdata  output  32  read beat data.
REQ-011 ctrl_rid  output  12  echoed arid.
REQ-012 ctrl_rresp  output  2  per-beat response.
REQ-013 ctrl_rlast  output  1  final read beat.
REQ-014 ctrl_rvalid  output  1  R valid.
REQ-015 ctrl_rready  input  1  R accept.
REQ-016 ctrl_awaddr  input  32  write burst start address.
REQ-017 ctrl_awid  input  12  write ID.
REQ-018 ctrl_awlen  input  4  write beats minus one.
REQ-019 ctrl_awvalid  input  1  AW valid.
REQ-020 ctrl_awready  output  1  AW accept.
REQ-021 ctrl_wdata  input  32  write beat data.
REQ-022 ctrl_wlast  input  1  master's final-beat flag.
REQ-023 ctrl_wvalid  input  1  W valid.
REQ-024 ctrl_wready  output  1  W accept.
REQ-025 ctrl_bid  output  12  echoed awid.
REQ-026 ctrl_bresp  output  2  burst response.
REQ-027 ctrl_bvalid  output  1  B valid.
REQ-028 ctrl_bready  input  1  B accept.
REQ-029 reg_req_valid  output  1  register access request.
REQ-030 reg_req_write  output  1  1=write, 0=read.
REQ-031 reg_req_addr  output  32  beat address minus C_CTRL_MEM0_BASEADDR.
REQ-032 reg_req_wdata  output  32  write data (ctrl_wdata pass-through).
REQ-033 reg_req_ready  input  1  request completes this cycle.
REQ-034 reg_rdata  input  32  read data, valid in cycle reg_req_valid&reg_req_ready&!reg_req_write.

Function
REQ-035 States IDLE, RD_ISSUE, RD_DATA, WR_DATA, WR_RESP; exactly one transaction outstanding; at most one of arready/awready high per cycle, both only in IDLE.
REQ-036 Arbitration in IDLE: single valid channel granted; both valid -> channel not granted last (round-robin); grant flag updates on AR or AW handshake.
REQ-037 AR handshake -> latch arid, araddr, arlen, beat counter=0, go RD_ISSUE; AW handshake -> latch awid, awaddr, awlen, counter=0, error flags clear, go WR_DATA.
REQ-038 Every beat address decoded individually (base<=addr<=high); beat address = start + 4*counter, 32-bit wrap, no 4KB check.
REQ-039 RD_ISSUE, hit: reg_req_valid=1, write=0; on ready capture reg_rdata, rresp=00, go RD_DATA. Miss: no request, rdata=32'hdeadd00d, rresp=11, go RD_DATA next cycle.
REQ-040 RD_DATA: rvalid=1, rlast=(counter==len), outputs held stable until rready; on handshake last -> IDLE else counter+1 -> RD_ISSUE; minimum AR-to-rvalid latency 2 cycles.
REQ-041 WR_DATA, hit: reg_req_valid=wvalid, write=1, wready=reg_req_ready; miss: wready=1, no request, sets DECERR flag; each W handshake increments counter.
REQ-042 W handshake with wlast != (counter==awlen) sets SLVERR flag; burst ends after awlen+1 beats regardless of wlast.
REQ-043 After final beat -> WR_RESP: bvalid=1, bid=awid, bresp = 11 if DECERR flag, else 10 if SLVERR flag, else 00; bready -> IDLE.
REQ-044 New AR/AW accepted in the cycle after returning to IDLE at the earliest.

Reset
REQ-045 RST_N low at a CLK edge: state IDLE, all ready/valid outputs 0, rdata/rid/rresp/rlast/bid/bresp 0, counter 0, grant flag = last-write (read wins first tie); in-flight burst abandoned with no response.

Verification
REQ-046 Read araddr=6e400010, arlen=0, reg_rdata=12345678, ready immediate -> reg_req_addr=10, rdata=12345678, rresp=00, rlast=1, rvalid 2 cycles after AR.
REQ-047 Write awlen=3 at 6e400000, 4 beats, ready stalls beat 2 for 3 cycles -> reg_req_addr 0,4,8,C in order, bresp=00, bid=awid.
REQ-048 AR and AW valid same cycle after reset -> read served first, then write; repeat tie -> write first.
REQ-049 Read arlen=1 at 6e4ffffc -> beat0 real data rresp=00, beat1 32'hdeadd00d rresp=11, one reg request only.
REQ-050 Write awlen=1 with wlast on beat 0 -> 2 beats accepted, bresp=10; write to 70000000 -> no reg request, bresp=11.
REQ-051 RST_N low during RD_DATA with rready=0 -> rvalid=0 next cycle, IDLE, new AR accepted normally.
